// File: rtl/poly_mod_sched_pkg.sv
// rtl/poly_mod_sched_pkg.sv - shared widths, FSM encodings and helpers for the poly_mod scheduler
package poly_mod_sched_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int DEGREE_N  = 4;
    localparam bit DEBUG     = 1'b1;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 3'd0;
    localparam sched_state_t ST_SETUP = 3'd1;
    localparam sched_state_t ST_FEED  = 3'd2;
    localparam sched_state_t ST_DRAIN = 3'd3;
    localparam sched_state_t ST_DONE  = 3'd4;

    // Width of a requester ID; never zero so single-bit tags stay legal.
    function automatic int tag_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_mod_sched_if.sv
// rtl/poly_mod_sched_if.sv - requester, poly_mod and consumer signals of the scheduler
interface poly_mod_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int W       = 16,
    parameter int TW      = 1
);
    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ-1:0][W-1:0]  q_i;
    logic [NUM_REQ-1:0][W-1:0]  coeff_i;
    logic [NUM_REQ-1:0]         valid_i;
    logic [NUM_REQ-1:0]         ready_o;

    logic                       pm_rst_n_o;
    logic [W-1:0]               pm_q_o;
    logic [W-1:0]               pm_coeff_o;
    logic                       pm_valid_o;
    logic [W-1:0]               pm_coeff_i;
    logic                       pm_valid_i;

    logic [W-1:0]               coeff_o;
    logic                       valid_o;
    logic [TW-1:0]              tag_o;
    logic                       last_o;
    logic [NUM_REQ-1:0]         done_o;
    logic                       busy_o;
    logic                       proto_err_o;

    modport slave (
        input  req_i, q_i, coeff_i, valid_i, pm_coeff_i, pm_valid_i,
        output ready_o, pm_rst_n_o, pm_q_o, pm_coeff_o, pm_valid_o,
               coeff_o, valid_o, tag_o, last_o, done_o, busy_o, proto_err_o
    );

    modport master (
        output req_i, q_i, coeff_i, valid_i, pm_coeff_i, pm_valid_i,
        input  ready_o, pm_rst_n_o, pm_q_o, pm_coeff_o, pm_valid_o,
               coeff_o, valid_o, tag_o, last_o, done_o, busy_o, proto_err_o
    );

endinterface

// File: rtl/poly_mod_sched_rr_arbiter.sv
// rtl/poly_mod_sched_rr_arbiter.sv - round-robin pick starting after the previous owner
module rr_arbiter
    import poly_mod_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int TW     = tag_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TW-1:0]      last,
    output logic [TW-1:0]      grant_id,
    output logic               any
);

    // Scan NUM_REQ slots in circular order beginning just after last; first hit wins.
    always_comb begin
        int idx;
        grant_id = last;
        any      = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                grant_id = TW'(idx);
            end
        end
    end

endmodule

// File: rtl/poly_mod_sched.sv
// rtl/poly_mod_sched.sv - round-robin sharing of one poly_mod reduction unit
module poly_mod_sched
    import poly_mod_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DEG     = DEGREE_N,
    parameter int W       = BIT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    poly_mod_sched_if.slave bus
);

    localparam int TW = tag_w(NUM_REQ);
    localparam int FW = $clog2(2 * DEG) + 1;
    localparam int OW = $clog2(DEG) + 1;

    localparam logic [FW-1:0] FEED_LAST = FW'(2 * DEG - 1);
    localparam logic [OW-1:0] OUT_LAST  = OW'(DEG - 1);
    localparam logic [OW-1:0] OUT_FULL  = OW'(DEG);
    localparam logic [TW-1:0] G_INIT    = TW'(NUM_REQ - 1);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [TW-1:0] g;
    logic [TW-1:0] last_g;
    logic [TW-1:0] arb_id;
    logic          arb_any;
    logic [W-1:0]  q_r;
    logic [FW-1:0] feed_cnt;
    logic [OW-1:0] out_cnt;
    logic          xfer;
    logic          fwd;
    logic          stray;
    logic          proto_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (bus.req_i),
        .last     (last_g),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    // Only the owner sees ready, and only while its product is being streamed in.
    always_comb begin
        bus.ready_o = '0;
        if (state == ST_FEED) begin
            bus.ready_o[g] = 1'b1;
        end
    end

    assign bus.pm_coeff_o  = bus.coeff_i[g];
    assign bus.pm_valid_o  = (state == ST_FEED) && bus.valid_i[g];
    assign bus.pm_rst_n_o  = !rst && (state != ST_SETUP);
    assign bus.pm_q_o      = q_r;
    assign bus.busy_o      = (state != ST_IDLE);
    assign bus.proto_err_o = proto_err;

    assign xfer  = bus.pm_valid_o;
    assign fwd   = bus.pm_valid_i && ((state == ST_FEED) || (state == ST_DRAIN));
    assign stray = bus.pm_valid_i && ((state == ST_IDLE) || (state == ST_SETUP));

    // Job sequencing; results may finish during FEED, but the feed must still complete.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = ST_FEED;
            ST_FEED:  if (xfer && feed_cnt == FEED_LAST) begin
                          state_nxt = ((out_cnt == OUT_FULL) || (fwd && out_cnt == OUT_LAST))
                                      ? ST_DONE : ST_DRAIN;
                      end
            ST_DRAIN: if (fwd && out_cnt == OUT_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Ownership, modulus latch and the feed/result counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            g        <= '0;
            last_g   <= G_INIT;
            q_r      <= '0;
            feed_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                feed_cnt <= feed_cnt + 1'b1;
            end
            if (fwd) begin
                out_cnt <= out_cnt + 1'b1;
            end
            if (state == ST_IDLE && arb_any) begin
                g        <= arb_id;
                q_r      <= bus.q_i[arb_id];
                feed_cnt <= '0;
                out_cnt  <= '0;
            end
            if (state == ST_DONE) begin
                last_g <= g;
            end
        end
    end

    // Registered result path to the consumer, plus the completion pulse after last_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.coeff_o <= '0;
            bus.valid_o <= 1'b0;
            bus.tag_o   <= '0;
            bus.last_o  <= 1'b0;
            bus.done_o  <= '0;
        end else begin
            bus.valid_o <= fwd;
            bus.last_o  <= fwd && (out_cnt == OUT_LAST);
            if (fwd) begin
                bus.coeff_o <= bus.pm_coeff_i;
                bus.tag_o   <= g;
            end
            bus.done_o <= '0;
            if (state == ST_DONE) begin
                bus.done_o[g] <= 1'b1;
            end
        end
    end

    // Sticky flag for results arriving while no job is streaming; they are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (DEBUG && stray) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_poly_mod_sched.sv
// tb/tb_poly_mod_sched.sv - directed table-driven bench for poly_mod_sched with a poly_mod model
module tb_poly_mod_sched;
    import poly_mod_sched_pkg::*;

    localparam int NR  = 2;
    localparam int D   = 4;
    localparam int W   = BIT_WIDTH;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_mod_sched_if #(.NUM_REQ(NR), .W(W), .TW(1)) bus ();

    poly_mod_sched #(.NUM_REQ(NR), .DEG(D), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] q);
        return (a >= b) ? (a - b) : (a - b + q);
    endfunction

    // Negacyclic reduction unit: stores N lower coefficients, emits lower-upper mod q.
    logic [W-1:0] pm_low [D];
    int           pm_cnt;
    logic [LAT-1:0] pv_pipe;
    logic [W-1:0] pc_pipe [LAT];
    logic         inject = 1'b0;

    always @(posedge clk) begin
        if (!bus.pm_rst_n_o) begin
            pm_cnt  <= 0;
            pv_pipe <= '0;
        end else begin
            pv_pipe <= {pv_pipe[LAT-2:0], 1'b0};
            for (int i = LAT - 1; i > 0; i--) pc_pipe[i] <= pc_pipe[i-1];
            if (bus.pm_valid_o) begin
                pm_cnt <= pm_cnt + 1;
                if (pm_cnt < D) begin
                    pm_low[pm_cnt] <= bus.pm_coeff_o;
                end else if (pm_cnt < 2 * D) begin
                    pv_pipe[0] <= 1'b1;
                    pc_pipe[0] <= sub_mod(pm_low[pm_cnt-D], bus.pm_coeff_o, bus.pm_q_o);
                end
            end
        end
    end

    assign bus.pm_valid_i = pv_pipe[LAT-1] | inject;
    assign bus.pm_coeff_i = pc_pipe[LAT-1];

    // Requester stream sources: always offering data[i][next], optionally with bubbles.
    logic [W-1:0] data [NR][2*D];
    int  idx  [NR];
    int  base [NR];
    bit  bubble [NR];
    bit  tog;

    initial begin
        for (int i = 0; i < NR; i++) begin
            idx[i] = 0; base[i] = 0; bubble[i] = 0;
            for (int k = 0; k < 2 * D; k++) data[i][k] = '0;
        end
        tog = 0;
        bus.valid_i = '0;
        bus.coeff_i = '0;
        forever begin
            @(negedge clk);
            tog = ~tog;
            for (int i = 0; i < NR; i++) begin
                bus.valid_i[i] = !(bubble[i] && tog);
                bus.coeff_i[i] = data[i][(idx[i] - base[i]) % (2 * D)];
                if (bus.ready_o[i] && bus.valid_i[i]) idx[i]++;
            end
        end
    end

    // Consumer-side monitor.
    typedef struct {
        logic [W-1:0] c;
        logic         t;
        logic         l;
    } res_t;

    res_t res_q [$];
    int   done_q [$];
    int   cyc = 0;
    int   last_cyc = -10;
    int   done_late = 0;
    int   both_ready = 0;
    int   pm_rst_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid_o) res_q.push_back('{bus.coeff_o, bus.tag_o, bus.last_o});
        if (bus.last_o) last_cyc = cyc;
        if (bus.done_o != '0) begin
            done_q.push_back(bus.done_o[1] ? 1 : 0);
            if (cyc != last_cyc + 1) done_late++;
        end
        if (&bus.ready_o) both_ready++;
        if (!rst && !bus.pm_rst_n_o) pm_rst_pulses++;
    end

    typedef struct {
        int id;
        int q;
        bit bub;
        logic [D-1:0][W-1:0] lo;
        logic [D-1:0][W-1:0] up;
        logic [D-1:0][W-1:0] ex;
    } vec_t;

    vec_t vt [4];

    function automatic logic [D-1:0][W-1:0] p4(input int a, input int b, input int c, input int d);
        logic [D-1:0][W-1:0] r;
        r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int id, input logic [D-1:0][W-1:0] lo, input logic [D-1:0][W-1:0] up,
                        input int q);
        for (int k = 0; k < D; k++) begin
            data[id][k]     = lo[k];
            data[id][k + D] = up[k];
        end
        base[id] = idx[id];
        bus.q_i[id] = W'(q);
    endtask

    task automatic wait_done(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({nm, "_done_seen"}, done_q.size() >= n, 1);
    endtask

    task automatic check_job(input string nm, input int tag, input logic [D-1:0][W-1:0] ex);
        res_t r;
        chk({nm, "_res_avail"}, res_q.size() >= D, 1);
        for (int i = 0; i < D; i++) begin
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                chk($sformatf("%s_coeff%0d", nm, i), r.c, ex[i]);
                chk($sformatf("%s_tag%0d", nm, i), r.t, tag);
                chk($sformatf("%s_last%0d", nm, i), r.l, (i == D - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int n0;
        load(v.id, v.lo, v.up, v.q);
        bubble[v.id] = v.bub;
        n0 = done_q.size();
        bus.req_i[v.id] = 1'b1;
        step();
        chk({nm, "_setup_busy"}, bus.busy_o, 1);
        chk({nm, "_setup_pmrst"}, bus.pm_rst_n_o, 0);
        chk({nm, "_setup_ready"}, bus.ready_o, 0);
        chk({nm, "_setup_q"}, bus.pm_q_o, v.q);
        step();
        chk({nm, "_feed_ready"}, bus.ready_o, 1 << v.id);
        bus.req_i[v.id] = 1'b0;
        wait_done(nm, n0 + 1, 80);
        if (done_q.size() > n0) chk({nm, "_done_id"}, done_q[n0], v.id);
        chk({nm, "_xfers"}, idx[v.id] - base[v.id], 2 * D);
        check_job(nm, v.id, v.ex);
        chk({nm, "_no_extra"}, res_q.size(), 0);
        res_q.delete();
        bubble[v.id] = 0;
    endtask

    int n0;
    int k;

    initial begin
        bus.req_i = '0;
        bus.q_i   = '0;

        vt[0] = '{0, 17, 1'b0, p4(5, 3, 0, 16), p4(2, 7, 1, 0), p4(3, 13, 16, 16)};
        vt[1] = '{0, 17, 1'b1, p4(5, 3, 0, 16), p4(2, 7, 1, 0), p4(3, 13, 16, 16)};
        vt[2] = '{1, 13, 1'b0, p4(10, 2, 12, 0), p4(3, 5, 12, 1), p4(7, 10, 0, 12)};
        vt[3] = '{1, 13, 1'b1, p4(12, 0, 6, 1), p4(12, 1, 0, 12), p4(0, 12, 6, 2)};

        rst = 1'b1;
        repeat (3) step();
        chk("rst_ready", bus.ready_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_last", bus.last_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_pm_valid", bus.pm_valid_o, 0);
        chk("rst_pm_rst_n", bus.pm_rst_n_o, 0);
        chk("rst_pm_q", bus.pm_q_o, 0);
        rst = 1'b0;
        step();
        chk("idle_pm_rst_n", bus.pm_rst_n_o, 1);

        // Stray result while idle: dropped, flagged.
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        chk("stray_fwd", res_q.size(), 0);
        chk("stray_flag", bus.proto_err_o, DEBUG ? 1 : 0);
        chk("stray_busy", bus.busy_o, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("stray_flag_clr", bus.proto_err_o, 0);

        // Table of single jobs; state returns to IDLE after each.
        for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Fairness: both held for four jobs.
        load(0, vt[0].lo, vt[0].up, 17);
        load(1, vt[2].lo, vt[2].up, 13);
        n0 = done_q.size();
        both_ready = 0;
        bus.req_i = 2'b11;
        wait_done("fair", n0 + 4, 400);
        bus.req_i = 2'b00;
        for (int j = 0; j < 4; j++) begin
            if (done_q.size() > n0 + j) chk($sformatf("fair_order%0d", j), done_q[n0 + j], j % 2);
            check_job($sformatf("fair_job%0d", j), j % 2, (j % 2 == 0) ? vt[0].ex : vt[2].ex);
        end
        chk("fair_exclusive", both_ready, 0);
        res_q.delete();

        // Requester 0 drops req after 3 coefficients; requester 1 arrives and must wait.
        repeat (2) step();
        load(0, vt[0].lo, vt[0].up, 17);
        load(1, vt[2].lo, vt[2].up, 13);
        n0 = done_q.size();
        bus.req_i[0] = 1'b1;
        k = 0;
        while (idx[0] - base[0] < 3 && k < 40) begin
            step();
            k++;
        end
        bus.req_i[0] = 1'b0;
        bus.req_i[1] = 1'b1;
        wait_done("drop0", n0 + 1, 80);
        chk("drop_r1_waited", idx[1] - base[1], 0);
        chk("drop_r0_xfers", idx[0] - base[0], 2 * D);
        step();
        bus.req_i[1] = 1'b0;
        wait_done("drop1", n0 + 2, 80);
        if (done_q.size() > n0 + 1) begin
            chk("drop_order0", done_q[n0], 0);
            chk("drop_order1", done_q[n0 + 1], 1);
        end
        check_job("drop_job0", 0, vt[0].ex);
        check_job("drop_job1", 1, vt[2].ex);
        res_q.delete();

        // Reset once the draining job has returned two results.
        load(0, vt[0].lo, vt[0].up, 17);
        bus.req_i[0] = 1'b1;
        step();
        bus.req_i[0] = 1'b0;
        k = 0;
        while (res_q.size() < 2 && k < 60) begin
            step();
            k++;
        end
        chk("abort_two_results", res_q.size(), 2);
        chk("abort_busy_before", bus.busy_o, 1);
        rst = 1'b1;
        step();
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_valid", bus.valid_o, 0);
        chk("abort_ready", bus.ready_o, 0);
        chk("abort_pm_rst_n", bus.pm_rst_n_o, 0);
        rst = 1'b0;
        res_q.delete();
        n0 = done_q.size();
        repeat (10) step();
        chk("abort_silent", res_q.size(), 0);
        chk("abort_no_done", done_q.size(), n0);
        chk("abort_idle", bus.busy_o, 0);
        run_vec("after_abort", vt[2]);

        // Back-to-back jobs with different moduli.
        load(0, p4(0, 0, 0, 0), p4(1, 1, 1, 1), 17);
        load(1, p4(0, 0, 0, 0), p4(1, 1, 1, 1), 13);
        n0 = done_q.size();
        pm_rst_pulses = 0;
        bus.req_i = 2'b11;
        wait_done("b2b", n0 + 2, 200);
        bus.req_i = 2'b00;
        if (done_q.size() > n0 + 1) begin
            chk("b2b_order0", done_q[n0], 0);
            chk("b2b_order1", done_q[n0 + 1], 1);
        end
        check_job("b2b_job0", 0, p4(16, 16, 16, 16));
        check_job("b2b_job1", 1, p4(12, 12, 12, 12));
        chk("b2b_pm_rst_pulses", pm_rst_pulses, 2);

        repeat (3) step();
        chk("done_after_last", done_late, 0);
        chk("never_both_ready", both_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly_mod_sched.md
# poly_mod_sched

Round-robin scheduler that shares one `poly_mod` reduction unit among several product-polynomial producers, such as multiplier lanes. Each granted requester streams its full 2N-coefficient product into the unit: N lower coefficients, then N upper. While that stream is in flight the scheduler blocks all other requesters. It counts the N reduced coefficients coming back, tags them with the owner's ID and returns them, then re-arbitrates. It also re-initialises the unit between jobs and muxes the per-requester modulus `q`.

## Interface
- `NUM_REQ`, default 2: number of requesters, at least 2.
- `DEG`, default `` `DEGREE_N ``: polynomial degree N, a power of two.
- `W`, default `` `BIT_WIDTH ``: coefficient width.
- `clk` in, 1: clock.
- `rst` in, 1: one clock; reset is synchronous and active-high.
- `req_i` in, NUM_REQ: requester wants the unit.
- `q_i` in, NUM_REQ×W: per-requester modulus, sampled at grant.
- `coeff_i` in, NUM_REQ×W: per-requester coefficient stream.
- `valid_i` in, NUM_REQ: coefficient valid.
- `ready_o` out, NUM_REQ: coefficient accepted when `valid_i & ready_o`.
- `pm_rst_n_o` out, 1: active-low reset to `poly_mod`.
- `pm_q_o` out, W: modulus to `poly_mod`.
- `pm_coeff_o` out, W: coefficient to `poly_mod`.
- `pm_valid_o` out, 1: coefficient valid to `poly_mod`.
- `pm_coeff_i` in, W: reduced coefficient from `poly_mod`.
- `pm_valid_i` in, 1: reduced coefficient valid.
- `coeff_o` out, W: reduced coefficient to consumer.
- `valid_o` out, 1: result valid. There is no backpressure; the consumer must always accept.
- `tag_o` out, $clog2(NUM_REQ): owner ID of `coeff_o`.
- `last_o` out, 1: marks the Nth result of a job.
- `done_o` out, NUM_REQ: one-cycle pulse when a job completes.
- `busy_o` out, 1: unit is owned.

## Operation
- States: IDLE, SETUP, FEED, DRAIN, DONE.
- IDLE:
  - Go to SETUP when `req_i` is non-zero.
  - Grant `g` goes to the first asserted request after `last_g`, in circular order.
  - Latch `g` and `q_i[g]`.
- SETUP:
  - One cycle with `pm_rst_n_o = 0`, which resets the unit's half counter and FIFOs.
  - Go to FEED.
- FEED:
  - `ready_o[g] = 1`; all other `ready_o` bits are 0.
  - `pm_coeff_o = coeff_i[g]` and `pm_valid_o = valid_i[g]`, combinationally.
  - `feed_cnt`, width $clog2(2·DEG)+1, increments on each transfer.
  - Bubbles are allowed.
  - When the transfer making `feed_cnt = 2·DEG` occurs, go to DRAIN.
- DRAIN:
  - No feeding.
  - Each `pm_valid_i` drives `coeff_o = pm_coeff_i`, `valid_o = 1`, `tag_o = g`.
  - `out_cnt`, width $clog2(DEG)+1, increments on each result.
  - On the result making `out_cnt = DEG`, assert `last_o` and go to DONE.
- DONE:
  - One cycle: `done_o[g] = 1`, `last_g <= g`, then go to IDLE.
- Result forwarding:
  - `pm_valid_i` during FEED is also forwarded and counted, because results begin once the upper half starts.
  - If `out_cnt` reaches DEG during FEED, it still waits for feed completion.
  - `last_o` fires on whichever result makes the count DEG.
- `busy_o = 1` in SETUP, FEED, DRAIN and DONE.
- Boundary cases:
  - Requester dropping `req_i` mid-job: ignored. The grant holds until all 2·DEG coefficients are accepted.
  - `pm_valid_i` in IDLE or SETUP: a protocol error. Drop it, do not forward it, and flag it under `` `DEBUG ``.
  - Requests arriving during a job: wait; no preemption.
  - Single requester: re-granted back-to-back with SETUP between jobs.
- Arithmetic: pass-through only. Reduction, `a − b` plus conditional `+ q`, is done in `poly_mod`.

## Timing
- Reset values:
  - State = IDLE; `last_g = NUM_REQ−1`, so requester 0 wins first after reset.
  - Both counters = 0.
  - All `ready_o`, `valid_o`, `last_o`, `done_o`, `busy_o` and `pm_valid_o` = 0.
  - `pm_rst_n_o` = 0 while `rst` is high; `pm_q_o` = 0.
- Reset mid-job aborts immediately. The next cycle is IDLE and the partial output is not completed.
- Grant latency: `req_i` seen in IDLE at cycle t means SETUP at t+1, and `ready_o[g]` high at t+2.
- Pass-through paths:
  - `ready_o`, `pm_coeff_o` and `pm_valid_o` are combinational from state and inputs.
  - `coeff_o`, `valid_o`, `tag_o` and `last_o` are registered, one cycle after `pm_valid_i`.
- `done_o` is asserted the cycle after `last_o`.
- Minimum job length, with no bubbles: 2·DEG + 2 cycles plus unit latency.

## Structure
- The state enum goes in `he_headers.sv`, alongside `` `BIT_WIDTH ``, `` `DEGREE_N `` and `` `DEBUG ``.
- The round-robin pick is a sub-module, `rr_arbiter` (parameter NUM_REQ; inputs `req`, `last`; outputs `grant_id`, `any`), reusable for other shared units.

## Test plan
All scenarios use DEG=4, NUM_REQ=2, q=17, with the real `poly_mod` attached.
- Single job: requester 0 sends lower [5,3,0,16] then upper [2,7,1,0] → outputs [3,13,16,16], `tag_o=0`, `last_o` on the 4th, `done_o=01` one cycle later.
- Fairness: both `req_i` held continuously for 4 jobs → grant order 0,1,0,1; `ready_o` is never high for both bits.
- Bubbles: `valid_i` toggles 1/0 during FEED → same outputs as the single-job case; `feed_cnt` counts only transfers.
- Drop request: requester 0 deasserts `req_i` after 3 coefficients but keeps sending → the job completes and requester 1 waits.
- Reset mid-DRAIN after 2 results → outputs are silent and state is IDLE. A new job from requester 1 then yields correct results with `tag_o=1`.
- Back-to-back jobs with different q: requester 0 uses q=17, requester 1 uses q=13, both sending lower [0,…], upper [1,…] → outputs 16s, then 12s; `pm_rst_n_o` pulses low between jobs.
